// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto one memory port,
// bounded fetch starvation and per-transaction timeout.
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int MAX_SKIP = 3,
   parameter int TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_be,
   input  logic [31:0]       m_rdata,
   input  logic              m_ack
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   state_t     state;
   logic [3:0] skip_cnt;
   logic [7:0] wait_cnt;
   logic       if_elig, d_elig, pick_if, timeout;
   // a requester whose ack is showing this cycle is still holding its old request
   assign if_elig = if_req && !if_ack;
   assign d_elig  = d_req && !d_ack;
   assign pick_if = if_elig && (!d_elig || skip_cnt == 4'(MAX_SKIP));
   assign timeout = wait_cnt == 8'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         skip_cnt <= '0;
         wait_cnt <= '0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_be     <= '0;
         if_ack   <= 1'b0;
         if_err   <= 1'b0;
         if_rdata <= '0;
         d_ack    <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= '0;
      end else begin
         if_ack <= 1'b0;
         if_err <= 1'b0;
         d_ack  <= 1'b0;
         d_err  <= 1'b0;
         if (state == IDLE) begin
            if (if_elig || d_elig) begin
               state    <= pick_if ? BUSY_I : BUSY_D;
               m_req    <= 1'b1;
               wait_cnt <= '0;
               m_addr   <= pick_if ? if_addr : d_addr;
               m_we     <= !pick_if && d_we;
               m_wdata  <= pick_if ? 32'h0 : d_wdata;
               m_be     <= pick_if ? 4'hF : d_be;
               skip_cnt <= pick_if ? 4'd0 :
                           (if_req && skip_cnt != 4'(MAX_SKIP)) ? skip_cnt + 4'd1 : skip_cnt;
            end
         end else if (m_ack || timeout) begin
            state <= IDLE;
            m_req <= 1'b0;
            if (state == BUSY_I) begin
               if_ack   <= 1'b1;
               if_err   <= !m_ack;
               if_rdata <= m_ack ? m_rdata : 32'h0;
            end else begin
               d_ack   <= 1'b1;
               d_err   <= !m_ack;
               d_rdata <= m_ack ? m_rdata : 32'h0;
            end
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end
endmodule
